// File: rtl/vitoria_seq.sv
// vitoria_seq: victory-screen ship sprite sequencer.
// One animation per start request: the ship rises from below the visible area
// to screen centre, holds there, optionally blinks, then reports done and
// waits for ack. Everything advances on a one-cycle frame tick, which is taken
// from the first blanking line of the shared VGA counters.
//
// Build option: define VITORIA_BLINK_EN to compile the BLINK phase. When it
// is undefined, HOLD goes straight to DONE and the sprite never blinks.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | sprite hidden below the screen, waiting for start
// RISE  | POS_Y moves up by STEP per frame until it reaches the centre
// HOLD  | sprite parked at the centre for HOLD_FRAMES frames
// BLINK | sprite_en toggles every BLINK_PERIOD frames (optional build)
// DONE  | sprite visible at the centre, waiting for ack

module vitoria_seq #(
    parameter int SCALE        = 6,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int STEP         = 2,
    parameter int HOLD_FRAMES  = 120
`ifdef VITORIA_BLINK_EN
    ,
    parameter int BLINK_PERIOD = 15,
    parameter int BLINK_FRAMES = 120
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       start,
    input  logic       ack,
    output logic [9:0] POS_X,
    output logic [9:0] POS_Y,
    output logic       sprite_en,
    output logic       busy,
    output logic       done
);

    localparam int SPRITE_PX  = 11 * SCALE;
    localparam int CENTER_X_I = (H_ACTIVE - SPRITE_PX) / 2;
    localparam int TARGET_Y_I = (V_ACTIVE - SPRITE_PX) / 2;

    localparam logic [9:0]  CENTER_X = 10'(CENTER_X_I);
    localparam logic [9:0]  TARGET_Y = 10'(TARGET_Y_I);
    localparam logic [9:0]  V_LINE   = 10'(V_ACTIVE);
    localparam logic [9:0]  STEP_Y   = 10'(STEP);
    localparam logic [9:0]  HOLD_LIM = 10'(HOLD_FRAMES);
    // Compare in 11 bits: "POS_Y - STEP <= TARGET_Y" rewritten so nothing
    // ever subtracts below zero.
    localparam logic [10:0] RISE_LIM = 11'(TARGET_Y_I + STEP);
`ifdef VITORIA_BLINK_EN
    localparam logic [9:0]  PERIOD_LIM = 10'(BLINK_PERIOD);
    localparam logic [9:0]  BLINK_LIM  = 10'(BLINK_FRAMES);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_HOLD,
`ifdef VITORIA_BLINK_EN
        S_BLINK,
`endif
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] pos_y, pos_y_nxt;
    logic       en, en_nxt;
    logic [9:0] cnt, cnt_nxt;
    logic [9:0] cnt_inc;
    logic       fcond, fcond_d, tick;
`ifdef VITORIA_BLINK_EN
    logic [9:0] phase, phase_nxt;
    logic [9:0] phase_inc;
`endif

    // The blanking condition can last several clocks; only its first clock
    // counts as the frame tick.
    assign fcond   = (h_counter == 10'd0) && (v_counter == V_LINE);
    assign tick    = fcond && !fcond_d;
    assign cnt_inc = cnt + 10'd1;
`ifdef VITORIA_BLINK_EN
    assign phase_inc = phase + 10'd1;
`endif

    // State, position, enable, counters and tick history; reset wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            pos_y   <= V_LINE;
            en      <= 1'b0;
            cnt     <= 10'd0;
            fcond_d <= 1'b0;
`ifdef VITORIA_BLINK_EN
            phase   <= 10'd0;
`endif
        end else begin
            state   <= state_nxt;
            pos_y   <= pos_y_nxt;
            en      <= en_nxt;
            cnt     <= cnt_nxt;
            fcond_d <= fcond;
`ifdef VITORIA_BLINK_EN
            phase   <= phase_nxt;
`endif
        end
    end

    // Next-state and datapath updates; everything holds unless a tick or a
    // start/ack handshake moves it.
    always_comb begin
        state_nxt = state;
        pos_y_nxt = pos_y;
        en_nxt    = en;
        cnt_nxt   = cnt;
`ifdef VITORIA_BLINK_EN
        phase_nxt = phase;
`endif
        case (state)
            S_IDLE: begin
                pos_y_nxt = V_LINE;
                en_nxt    = 1'b0;
                cnt_nxt   = 10'd0;
`ifdef VITORIA_BLINK_EN
                phase_nxt = 10'd0;
`endif
                if (start) begin
                    state_nxt = S_RISE;
                    en_nxt    = 1'b1;
                end
            end
            S_RISE: begin
                if (tick) begin
                    if ({1'b0, pos_y} <= RISE_LIM) begin
                        pos_y_nxt = TARGET_Y;
                        cnt_nxt   = 10'd0;
                        state_nxt = S_HOLD;
                    end else begin
                        pos_y_nxt = pos_y - STEP_Y;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (cnt_inc == HOLD_LIM) begin
                        cnt_nxt   = 10'd0;
`ifdef VITORIA_BLINK_EN
                        phase_nxt = 10'd0;
                        state_nxt = S_BLINK;
`else
                        en_nxt    = 1'b1;
                        state_nxt = S_DONE;
`endif
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
`ifdef VITORIA_BLINK_EN
            S_BLINK: begin
                if (tick) begin
                    cnt_nxt   = cnt_inc;
                    phase_nxt = phase_inc;
                    if (phase_inc == PERIOD_LIM) begin
                        en_nxt    = !en;
                        phase_nxt = 10'd0;
                    end
                    // Always finish with the ship visible, whatever the phase.
                    if (cnt_inc == BLINK_LIM) begin
                        en_nxt    = 1'b1;
                        cnt_nxt   = 10'd0;
                        phase_nxt = 10'd0;
                        state_nxt = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                    en_nxt    = 1'b0;
                    pos_y_nxt = V_LINE;
                    cnt_nxt   = 10'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                en_nxt    = 1'b0;
                pos_y_nxt = V_LINE;
                cnt_nxt   = 10'd0;
            end
        endcase
    end

    // Status comes straight from the registered state, so busy and done can
    // never be high together.
    always_comb begin
        POS_X     = CENTER_X;
        POS_Y     = pos_y;
        sprite_en = en;
        busy      = (state == S_RISE) || (state == S_HOLD)
`ifdef VITORIA_BLINK_EN
                    || (state == S_BLINK)
`endif
                    ;
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_vitoria_seq.sv
// Bench for vitoria_seq: randomized frame timing and ignored-input noise,
// checked against a frame-count reference model through a scoreboard queue.
module tb_vitoria_seq;

    localparam int V_ACT    = 480;
    localparam int CX       = (640 - 66) / 2;
    localparam int TGT      = (V_ACT - 66) / 2;
    localparam int STP      = 2;
    localparam int RISE_N   = (V_ACT - TGT + STP - 1) / STP;
    localparam int HOLD_N   = 120;
    localparam int PERIOD_N = 15;
    localparam int BLINK_N  = 120;
`ifdef VITORIA_BLINK_EN
    localparam int TOTAL_N  = RISE_N + HOLD_N + BLINK_N;
`else
    localparam int TOTAL_N  = RISE_N + HOLD_N;
`endif

    logic       clk = 1'b0;
    logic       reset, start, ack;
    logic [9:0] h_counter, v_counter;
    logic [9:0] POS_X, POS_Y;
    logic       sprite_en, busy, done;

    always #5 clk = ~clk;

    vitoria_seq dut (
        .clk       (clk),
        .reset     (reset),
        .h_counter (h_counter),
        .v_counter (v_counter),
        .start     (start),
        .ack       (ack),
        .POS_X     (POS_X),
        .POS_Y     (POS_Y),
        .sprite_en (sprite_en),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int px;
        int py;
        bit en;
        bit bs;
        bit dn;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 idle, 1 animating, 2 done; m_frames counts
    // frame ticks since start.
    int m_mode   = 0;
    int m_frames = 0;
    bit m_prev   = 1'b0;

    function automatic exp_t expect_now();
        exp_t e;
        int   b;
        e.px = CX;
        e.py = V_ACT;
        e.en = 1'b0;
        e.bs = 1'b0;
        e.dn = 1'b0;
        if (m_mode == 1) begin
            e.bs = 1'b1;
            e.py = V_ACT - STP * m_frames;
            if (e.py < TGT) e.py = TGT;
            e.en = 1'b1;
`ifdef VITORIA_BLINK_EN
            b = m_frames - RISE_N - HOLD_N;
            if (b >= 0) e.en = ((b / PERIOD_N) % 2) == 0;
`else
            b = 0;
`endif
        end else if (m_mode == 2) begin
            e.py = TGT;
            e.en = 1'b1;
            e.dn = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit a, input bit fc);
        bit tk;
        tk = fc && !m_prev;
        if (!r) begin
            m_mode   = 0;
            m_frames = 0;
            m_prev   = 1'b0;
            return;
        end
        m_prev = fc;
        case (m_mode)
            0: if (s) begin
                m_mode   = 1;
                m_frames = 0;
            end
            1: if (tk) begin
                m_frames++;
                if (m_frames == TOTAL_N) m_mode = 2;
            end
            default: if (a) m_mode = 0;
        endcase
    endfunction

    // One clock: drive on the falling edge, update the model at the rising
    // edge and queue what the outputs must show afterwards.
    task automatic cyc(input bit r, input bit s, input bit a, input bit fc);
        @(negedge clk);
        reset = r;
        start = s;
        ack   = a;
        if (fc) begin
            h_counter = 10'd0;
            v_counter = 10'(V_ACT);
        end else begin
            h_counter = 10'($urandom_range(0, 799));
            v_counter = ($urandom_range(0, 1) == 0) ? 10'(V_ACT) : 10'($urandom_range(0, 524));
            if (h_counter == 10'd0 && v_counter == 10'(V_ACT)) h_counter = 10'd1;
        end
        @(posedge clk);
        model_step(r, s, a, fc);
        q.push_back(expect_now());
    endtask

    // One frame: fcond held 1..4 clocks, then 1..3 clocks elsewhere. While
    // animating, start and ack are sprinkled in and must be ignored.
    task automatic frame();
        int  on_n, off_n;
        bit  s, a;
        on_n  = $urandom_range(1, 4);
        off_n = $urandom_range(1, 3);
        for (int i = 0; i < on_n + off_n; i++) begin
            s = (m_mode == 1) && ($urandom_range(0, 4) == 0);
            a = (m_mode == 1) && ($urandom_range(0, 4) == 0);
            cyc(1'b1, s, a, i < on_n);
        end
    endtask

    // Monitor: every queued expectation is compared against the outputs the
    // DUT holds on the following falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (int'(POS_X) != e.px || int'(POS_Y) != e.py || sprite_en != e.en ||
                busy != e.bs || done != e.dn || (busy && done)) begin
                bad++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d en=%0b busy=%0b done=%0b want x=%0d y=%0d en=%0b busy=%0b done=%0b",
                         $time, POS_X, POS_Y, sprite_en, busy, done, e.px, e.py, e.en, e.bs, e.dn);
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b0;
        start     = 1'b1;
        ack       = 1'b0;
        h_counter = 10'd1;
        v_counter = 10'd0;

        // reset held with start high
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);          // ack in idle is ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b1);          // tick in idle moves nothing
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // full animation
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_mode == 1 && n < TOTAL_N + 20) begin
            frame();
            n++;
        end
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1); // start and ticks in done ignored
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // start coincident with a tick, then reset at rise tick 50
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (m_mode == 1 && m_frames < 50 && n < 80) begin
            frame();
            n++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // replay from the bottom, finish with start+ack in done (ack wins)
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_mode == 1 && n < TOTAL_N + 20) begin
            frame();
            n++;
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);           // both high in idle: start wins
        repeat (4) frame();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
